// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: operating modes plus elaboration-time builders for
// the arctangent table and the gain-compensation constant.
package cordic_pkg;

    typedef enum logic {
        CORDIC_ROTATE = 1'b0,
        CORDIC_VECTOR = 1'b1
    } cordic_mode_e;

    localparam int CORDIC_MAX_STAGES = 32;
    localparam int CORDIC_ANGLE_W    = 32;
    localparam int CORDIC_GAIN_FRAC  = 16;

    typedef logic [CORDIC_MAX_STAGES*CORDIC_ANGLE_W-1:0] cordic_atan_tbl_t;

    // Entry k sits at bits [k*CORDIC_ANGLE_W +: CORDIC_ANGLE_W], in units of 1/2^pw turn.
    function automatic cordic_atan_tbl_t cordic_atan_table(input int pw, input int nstages);
        cordic_atan_tbl_t tbl;
        real              pi_r;
        real              scale_r;
        real              ang_r;
        tbl     = '0;
        pi_r    = 4.0 * $atan(1.0);
        scale_r = (2.0 ** pw) / (2.0 * pi_r);
        for (int k = 0; k < nstages; k++) begin
            ang_r = $atan(1.0 / (2.0 ** k)) * scale_r;
            tbl[k*CORDIC_ANGLE_W +: CORDIC_ANGLE_W] = CORDIC_ANGLE_W'($rtoi(ang_r + 0.5));
        end
        return tbl;
    endfunction

    // Unsigned Q0.16 reciprocal of the accumulated CORDIC gain.
    function automatic logic [CORDIC_GAIN_FRAC-1:0] cordic_gain_comp(input int nstages);
        real k_gain_r;
        k_gain_r = 1.0;
        for (int k = 0; k < nstages; k++) begin
            k_gain_r = k_gain_r * $sqrt(1.0 + 1.0 / (2.0 ** (2 * k)));
        end
        return CORDIC_GAIN_FRAC'($rtoi((2.0 ** CORDIC_GAIN_FRAC) / k_gain_r + 0.5));
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation with shift K; direction follows the
// phase sign (rotation) or the y sign (vectoring).
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int             WW   = 18,
    parameter int             PW   = 16,
    parameter int             K    = 0,
    parameter logic [PW-1:0]  ATAN = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  cordic_mode_e         i_mode,
    input  logic signed [WW-1:0] i_x,
    input  logic signed [WW-1:0] i_y,
    input  logic [PW-1:0]        i_p,
    output logic signed [WW-1:0] o_x,
    output logic signed [WW-1:0] o_y,
    output logic [PW-1:0]        o_p
);

    logic signed [WW-1:0] w_xs;
    logic signed [WW-1:0] w_ys;
    logic signed [WW-1:0] w_xn;
    logic signed [WW-1:0] w_yn;
    logic [PW-1:0]        w_pn;
    logic                 w_ccw;

    assign w_xs = i_x >>> K;
    assign w_ys = i_y >>> K;

    // Rotation chases the residual phase to zero; vectoring chases y to zero.
    always_comb begin
        w_ccw = 1'b0;
        if (i_mode == CORDIC_ROTATE) begin
            w_ccw = ~i_p[PW-1];
        end else begin
            w_ccw = i_y[WW-1];
        end
    end

    // A counter-clockwise step always consumes angle; clockwise always adds it.
    always_comb begin
        w_xn = i_x;
        w_yn = i_y;
        w_pn = i_p;
        if (w_ccw) begin
            w_xn = i_x - w_ys;
            w_yn = i_y + w_xs;
            w_pn = i_p - ATAN;
        end else begin
            w_xn = i_x + w_ys;
            w_yn = i_y - w_xs;
            w_pn = i_p + ATAN;
        end
    end

    // Stage register; holds while the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_x <= '0;
            o_y <= '0;
            o_p <= '0;
        end else if (enable) begin
            o_x <= w_xn;
            o_y <= w_yn;
            o_p <= w_pn;
        end else begin
            o_x <= o_x;
            o_y <= o_y;
            o_p <= o_p;
        end
    end

endmodule

// File: rtl/cordic_multimode.sv
// Pipelined CORDIC with per-sample rotation/vectoring selection, gain
// compensation and saturating outputs; latency NSTAGES+2 enabled cycles.
module cordic_multimode
    import cordic_pkg::*;
#(
    parameter int IW      = 16,
    parameter int PW      = 16,
    parameter int NSTAGES = 14,
    parameter int OW      = IW + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 i_valid,
    input  logic                 i_mode,
    input  logic signed [IW-1:0] i_xval,
    input  logic signed [IW-1:0] i_yval,
    input  logic [PW-1:0]        i_phase,
    output logic                 o_valid,
    output logic                 o_mode,
    output logic signed [OW-1:0] o_xval,
    output logic signed [OW-1:0] o_yval,
    output logic [PW-1:0]        o_phase
);

    localparam int WW = IW + 2;
    localparam int MW = WW + CORDIC_GAIN_FRAC + 1;

    localparam cordic_atan_tbl_t ATAN_TBL = cordic_atan_table(PW, NSTAGES);
    localparam logic [CORDIC_GAIN_FRAC-1:0] GAIN = cordic_gain_comp(NSTAGES);

    localparam logic [PW-1:0] QUARTER_TURN = {2'b01, {(PW-2){1'b0}}};
    localparam logic [PW-1:0] HALF_TURN    = {2'b10, {(PW-2){1'b0}}};
    localparam logic [PW-1:0] THREEQ_TURN  = {2'b11, {(PW-2){1'b0}}};

    localparam logic signed [MW-1:0] SAT_HI = {{(MW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [MW-1:0] SAT_LO = {{(MW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    // Scale by 1/K in Q0.16 and clamp into the signed output range.
    function automatic logic signed [OW-1:0] gain_sat(input logic signed [WW-1:0] v);
        logic signed [MW-1:0] prod;
        logic signed [MW-1:0] scaled;
        logic signed [MW-1:0] gain_s;
        gain_s = $signed({{(MW-CORDIC_GAIN_FRAC){1'b0}}, GAIN});
        prod   = MW'(v) * gain_s;
        scaled = prod >>> CORDIC_GAIN_FRAC;
        if (scaled > SAT_HI) begin
            return SAT_HI[OW-1:0];
        end else if (scaled < SAT_LO) begin
            return SAT_LO[OW-1:0];
        end else begin
            return scaled[OW-1:0];
        end
    endfunction

    cordic_mode_e         w_in_mode;
    logic signed [WW-1:0] w_xin;
    logic signed [WW-1:0] w_yin;
    logic signed [WW-1:0] w_x0n;
    logic signed [WW-1:0] w_y0n;
    logic [PW-1:0]        w_p0n;

    logic signed [WW-1:0] r_x0;
    logic signed [WW-1:0] r_y0;
    logic [PW-1:0]        r_p0;
    logic [NSTAGES+1:0]   r_vld;
    logic [NSTAGES+1:0]   r_mode;

    logic signed [WW-1:0] w_x [NSTAGES+1];
    logic signed [WW-1:0] w_y [NSTAGES+1];
    logic [PW-1:0]        w_p [NSTAGES+1];

    assign w_in_mode = cordic_mode_e'(i_mode);
    assign w_xin     = {{(WW-IW){i_xval[IW-1]}}, i_xval};
    assign w_yin     = {{(WW-IW){i_yval[IW-1]}}, i_yval};

    // Coarse pre-rotation: quarter turns bring the residual into +/-45 deg, or
    // the vector into the right half-plane.
    always_comb begin
        w_x0n = w_xin;
        w_y0n = w_yin;
        w_p0n = i_phase;
        if (w_in_mode == CORDIC_VECTOR) begin
            if (w_xin[WW-1]) begin
                w_x0n = -w_xin;
                w_y0n = -w_yin;
                w_p0n = HALF_TURN;
            end else begin
                w_p0n = '0;
            end
        end else begin
            case (i_phase[PW-1:PW-3])
                3'd1, 3'd2: begin
                    w_x0n = -w_yin;
                    w_y0n = w_xin;
                    w_p0n = i_phase - QUARTER_TURN;
                end
                3'd3, 3'd4: begin
                    w_x0n = -w_xin;
                    w_y0n = -w_yin;
                    w_p0n = i_phase - HALF_TURN;
                end
                3'd5, 3'd6: begin
                    w_x0n = w_yin;
                    w_y0n = -w_xin;
                    w_p0n = i_phase - THREEQ_TURN;
                end
                default: begin
                    w_p0n = i_phase;
                end
            endcase
        end
    end

    // Pre-rotation register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x0 <= '0;
            r_y0 <= '0;
            r_p0 <= '0;
        end else if (enable) begin
            r_x0 <= w_x0n;
            r_y0 <= w_y0n;
            r_p0 <= w_p0n;
        end else begin
            r_x0 <= r_x0;
            r_y0 <= r_y0;
            r_p0 <= r_p0;
        end
    end

    // Valid/mode side-band: bit 0 pairs with the pre-rotation register, the
    // top bit with the output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld  <= '0;
            r_mode <= '0;
        end else if (enable) begin
            r_vld  <= {r_vld[NSTAGES:0], i_valid};
            r_mode <= {r_mode[NSTAGES:0], i_mode};
        end else begin
            r_vld  <= r_vld;
            r_mode <= r_mode;
        end
    end

    assign w_x[0] = r_x0;
    assign w_y[0] = r_y0;
    assign w_p[0] = r_p0;

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        cordic_stage #(
            .WW   (WW),
            .PW   (PW),
            .K    (k),
            .ATAN (PW'(ATAN_TBL[k*CORDIC_ANGLE_W +: CORDIC_ANGLE_W]))
        ) u_stage (
            .clk    (clk),
            .reset  (reset),
            .enable (enable),
            .i_mode (cordic_mode_e'(r_mode[k])),
            .i_x    (w_x[k]),
            .i_y    (w_y[k]),
            .i_p    (w_p[k]),
            .o_x    (w_x[k+1]),
            .o_y    (w_y[k+1]),
            .o_p    (w_p[k+1])
        );
    end

    // Gain-compensated, saturated output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_xval  <= '0;
            o_yval  <= '0;
            o_phase <= '0;
        end else if (enable) begin
            o_xval  <= gain_sat(w_x[NSTAGES]);
            o_yval  <= gain_sat(w_y[NSTAGES]);
            o_phase <= w_p[NSTAGES];
        end else begin
            o_xval  <= o_xval;
            o_yval  <= o_yval;
            o_phase <= o_phase;
        end
    end

    assign o_valid = r_vld[NSTAGES+1];
    assign o_mode  = r_mode[NSTAGES+1];

endmodule

// File: tb/tb_cordic_multimode.sv
// Self-checking bench for cordic_multimode: directed and randomized samples
// against a floating-point trigonometric reference with a latency scoreboard.
module tb_cordic_multimode;

    localparam int  IW      = 16;
    localparam int  PW      = 16;
    localparam int  NSTAGES = 14;
    localparam int  OW      = IW + 1;
    localparam int  LAT     = NSTAGES + 2;
    localparam real PI_R    = 3.14159265358979323846;
    localparam real PH_SC   = 65536.0 / (2.0 * PI_R);
    localparam int  OMAX    = 65535;
    localparam int  OMIN    = -65536;

    localparam int K_NONE  = 0;
    localparam int K_EN    = 1;
    localparam int K_STALL = 2;
    localparam int K_RST   = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic                 i_valid;
    logic                 i_mode;
    logic signed [IW-1:0] i_xval;
    logic signed [IW-1:0] i_yval;
    logic [PW-1:0]        i_phase;
    logic                 o_valid;
    logic                 o_mode;
    logic signed [OW-1:0] o_xval;
    logic signed [OW-1:0] o_yval;
    logic [PW-1:0]        o_phase;

    cordic_multimode #(.IW(IW), .PW(PW), .NSTAGES(NSTAGES), .OW(OW)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .i_valid (i_valid),
        .i_mode  (i_mode),
        .i_xval  (i_xval),
        .i_yval  (i_yval),
        .i_phase (i_phase),
        .o_valid (o_valid),
        .o_mode  (o_mode),
        .o_xval  (o_xval),
        .o_yval  (o_yval),
        .o_phase (o_phase)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic mode;
        int   x;
        int   y;
        int   ph;
        int   xy_tol;
        int   ph_tol;
        int   due;
    } exp_t;

    exp_t q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   en_cnt    = 0;
    int   last_kind = K_NONE;
    logic prev_valid;
    logic prev_mode;
    int   prev_x;
    int   prev_y;
    int   prev_ph;

    task automatic chk_eq(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input int expv, input int tol);
        logic in_tol;
        checks++;
        in_tol = ((obs - expv) <= tol) && ((expv - obs) <= tol);
        assert (in_tol === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, expv, tol);
        end
    endtask

    task automatic chk_ph(input string tag, input int obs, input int expv, input int tol);
        logic [15:0] dd;
        int          d;
        logic        in_tol;
        checks++;
        dd     = 16'(obs - expv);
        d      = int'($signed(dd));
        in_tol = (d <= tol) && (-d <= tol);
        assert (in_tol === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, expv, tol);
        end
    endtask

    function automatic int clamp_o(input real v);
        int r;
        r = int'(v);
        if (r > OMAX) r = OMAX;
        if (r < OMIN) r = OMIN;
        return r;
    endfunction

    // Ideal result: plane rotation, or polar magnitude/angle of the vector.
    function automatic exp_t model(input logic mode, input int x, input int y, input int ph,
                                   input int xy_tol, input int ph_tol);
        exp_t e;
        real  th;
        real  mag;
        real  xr;
        real  yr;
        mag = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
        e.mode   = mode;
        e.ph_tol = ph_tol;
        e.xy_tol = (xy_tol >= 0) ? xy_tol : 6 + int'(mag * 0.0008);
        e.due    = 0;
        if (mode == 1'b0) begin
            th   = real'(ph) / PH_SC;
            xr   = real'(x) * $cos(th) - real'(y) * $sin(th);
            yr   = real'(x) * $sin(th) + real'(y) * $cos(th);
            e.ph = 0;
        end else begin
            xr   = mag;
            yr   = 0.0;
            e.ph = int'($atan2(real'(y), real'(x)) * PH_SC);
            if (e.ph < 0) e.ph = e.ph + 65536;
            e.ph = e.ph % 65536;
        end
        e.x = clamp_o(xr);
        e.y = clamp_o(yr);
        return e;
    endfunction

    task automatic check_outputs();
        exp_t e;
        logic exp_v;
        if (last_kind == K_RST) begin
            chk_eq("reset_valid", o_valid, 0);
            chk_eq("reset_mode", o_mode, 0);
            chk_eq("reset_x", o_xval, 0);
            chk_eq("reset_y", o_yval, 0);
            chk_eq("reset_phase", o_phase, 0);
        end else if (last_kind == K_STALL) begin
            chk_eq("stall_valid", o_valid, prev_valid);
            chk_eq("stall_mode", o_mode, prev_mode);
            chk_eq("stall_x", o_xval, prev_x);
            chk_eq("stall_y", o_yval, prev_y);
            chk_eq("stall_phase", o_phase, prev_ph);
        end else if (last_kind == K_EN) begin
            exp_v = (q.size() > 0) && (q[0].due == en_cnt);
            chk_eq("valid", o_valid, exp_v);
            if (exp_v) begin
                e = q.pop_front();
                if (o_valid === 1'b1) begin
                    chk_eq("mode", o_mode, e.mode);
                    chk_tol("xval", o_xval, e.x, e.xy_tol);
                    chk_tol("yval", o_yval, e.y, e.xy_tol);
                    chk_ph("phase", o_phase, e.ph, e.ph_tol);
                end
            end
        end
        prev_valid = o_valid;
        prev_mode  = o_mode;
        prev_x     = o_xval;
        prev_y     = o_yval;
        prev_ph    = o_phase;
    endtask

    // One clock: check what the previous edge produced, drive, then book-keep.
    task automatic step(input logic rst, input logic en, input logic vld, input logic mode,
                        input int x, input int y, input int ph, input int xy_tol, input int ph_tol);
        exp_t e;
        @(negedge clk);
        check_outputs();
        reset   = rst;
        enable  = en;
        i_valid = vld;
        i_mode  = mode;
        i_xval  = IW'(x);
        i_yval  = IW'(y);
        i_phase = PW'(ph);
        @(posedge clk);
        if (rst) begin
            q.delete();
            last_kind = K_RST;
        end else if (en) begin
            en_cnt++;
            if (vld) begin
                e     = model(mode, x, y, ph, xy_tol, ph_tol);
                e.due = en_cnt + LAT - 1;
                q.push_back(e);
            end
            last_kind = K_EN;
        end else begin
            last_kind = K_STALL;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, -1, 16);
    endtask

    task automatic rand_sample(input logic mode, output int x, output int y, output int ph);
        real a;
        real m;
        if (mode == 1'b0) begin
            x  = int'($signed(16'($urandom)));
            y  = int'($signed(16'($urandom)));
            ph = int'($urandom_range(0, 65535));
        end else begin
            a  = real'($urandom_range(0, 65535)) / PH_SC;
            m  = real'($urandom_range(8192, 32000));
            x  = int'(m * $cos(a));
            y  = int'(m * $sin(a));
            ph = int'($urandom_range(0, 65535));
        end
    endtask

    initial begin
        int   x;
        int   y;
        int   ph;
        logic md;
        reset   = 1'b1;
        enable  = 1'b0;
        i_valid = 1'b0;
        i_mode  = 1'b0;
        i_xval  = '0;
        i_yval  = '0;
        i_phase = '0;

        // Reset while enable is low must still clear everything.
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, -1, 16);
        step(1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 0, -1, 16);
        idle(2);

        // Directed angles and extreme inputs.
        step(1'b0, 1'b1, 1'b1, 1'b0, 16384, 0, 16'h2000, 4, 8);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16384, 0, 16'hC000, 4, 8);
        step(1'b0, 1'b1, 1'b1, 1'b1, 0, 10000, 0, 4, 8);
        step(1'b0, 1'b1, 1'b1, 1'b1, -10000, 0, 0, 4, 8);
        step(1'b0, 1'b1, 1'b1, 1'b0, -32768, -32768, 16'h1234, -1, 8);
        step(1'b0, 1'b1, 1'b1, 1'b1, -32768, -32768, 0, -1, 16);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32767, 32767, 16'h2000, -1, 8);
        step(1'b0, 1'b1, 1'b1, 1'b0, -32768, 32767, 16'h6000, -1, 8);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32767, -32768, 0, -1, 16);
        idle(LAT + 2);

        // 32 back-to-back samples, alternating modes, 3-cycle stall in the middle.
        for (int i = 0; i < 32; i++) begin
            if (i == 16) begin
                for (int s = 0; s < 3; s++) begin
                    rand_sample(1'b0, x, y, ph);
                    step(1'b0, 1'b0, 1'b1, 1'b1, x, y, ph, -1, 16);
                end
            end
            md = 1'(i % 2);
            rand_sample(md, x, y, ph);
            step(1'b0, 1'b1, 1'b1, md, x, y, ph, -1, (md == 1'b1) ? 16 : 8);
        end
        idle(LAT + 2);

        // Random valid/enable/mode traffic.
        for (int i = 0; i < 150; i++) begin
            md = 1'($urandom_range(0, 1));
            rand_sample(md, x, y, ph);
            step(1'b0, ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0), md, x, y, ph, -1,
                 (md == 1'b1) ? 16 : 8);
        end
        idle(LAT + 2);

        // Ten-sample burst with a reset on the sixth cycle.
        for (int i = 0; i < 10; i++) begin
            md = 1'($urandom_range(0, 1));
            rand_sample(md, x, y, ph);
            step((i == 5), 1'b1, 1'b1, md, x, y, ph, -1, (md == 1'b1) ? 16 : 8);
        end
        idle(LAT + 2);

        chk_eq("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
